vga_fb_reader: RTL and testbench
================================

# vga_fb_reader

Display-side reader of the frame buffer that the camera capture path fills. It generates 640×480@60 VGA timing on the pixel clock and issues linear read addresses to the frame buffer's read port. It unpacks each 12-bit stored pixel into 4:4:4 RGB and drives the VGA pins with blanking and syncs aligned to the data. It sits between the dual-port frame buffer read port and the board DAC or connector.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines
- FB_W, 640, stored pixels per frame-buffer line
- SCALE_SHIFT, 0, pixel and line replication factor as log2; 0 = 1:1, 1 = 2×2 (QVGA buffer)
- ADDR_W, 19, frame-buffer address width
- pclk  in  1  VGA pixel clock, 25 MHz nominal; the only clock
- rst_n  in  1  synchronous, active-low reset
- fb_addr  out  ADDR_W  frame-buffer read address, registered
- fb_re  out  1  read enable, high only for active pixels
- fb_data  in  12  read data from synchronous RAM, valid 1 cycle after fb_addr/fb_re; format [11:8]=G, [7:4]=R, [3:0]=B
- vga_r / vga_g / vga_b  out  4 each  colour outputs
- vga_hsync_n / vga_vsync_n  out  1 each  active-low syncs
- vga_de  out  1  data enable, aligned with the colour outputs
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the pins

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 at the default parameters.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt advances on each h wrap and wraps 0..V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [656,751] at defaults.
- vsync is low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is [490,491] at defaults. vsync changes at the h_cnt=0 boundary.
- Address generation uses no multiplier:
  - line_base holds (v_cnt >> SCALE_SHIFT)·FB_W.
  - fb_addr = line_base + (h_cnt >> SCALE_SHIFT).
  - line_base resets to 0 when v_cnt wraps. It increases by FB_W at the end of each active line where the low SCALE_SHIFT bits of v_cnt are all 1.
  - Arithmetic is ADDR_W wide with no saturation. Parameter sets must keep the frame within 2^ADDR_W.
- fb_re = 1 only for active pixels. fb_addr holds its last value while fb_re = 0.
- Unpacking: vga_r = fb_data[7:4], vga_g = fb_data[11:8], vga_b = fb_data[3:0].
- Colour outputs are forced to 0 whenever the delayed vga_de = 0, regardless of fb_data.
- Reset values: vga_hsync_n = 1, vga_vsync_n = 1, vga_r/g/b = 0, vga_de = 0, fb_re = 0, fb_addr = 0, frame_start = 0. Reset also clears h_cnt, v_cnt, line_base and all pipeline stages.
- Reset mid-frame: every output goes to its reset value on the first sampled-low edge. On release the block restarts a full frame at pixel (0,0), address 0, with no partial line.

## Timing
- Three-stage pipeline:
  - t0: counters.
  - t1: fb_addr/fb_re registered.
  - t2: fb_data valid from the RAM.
  - t3: pins registered.
- hsync, vsync, de and frame_start are delayed so they are cycle-aligned with rgb at t3.
- After reset release, edge E0 is the first edge with rst_n = 1:
  - After E0: fb_addr = 0 and fb_re = 1.
  - After E2: vga_de = 1 and frame_start = 1, with rgb from address 0.
- Steady-state period: exactly H_TOTAL cycles per line and H_TOTAL·V_TOTAL = 420000 cycles per frame.
- fb_re is asserted for exactly H_ACTIVE·V_ACTIVE = 307200 cycles per frame.

## Structure
- Shared package vga_pkg holds:
  - the default timing constants;
  - the derived H_TOTAL and V_TOTAL;
  - the pixel field offsets (G 11:8, R 7:4, B 3:0), shared with the capture block.
- Sub-module vga_timing owns h_cnt, v_cnt, the raw sync/active flags, and a line_end/frame_end strobe.
- vga_fb_reader contains vga_timing, the address generator, and the alignment pipeline.

## Test plan
- Reset, then run 2 frames. Check for 800 cycles per line and 525 lines. hsync must be low 96 cycles, starting 656 cycles after each de rise. vsync must be low for exactly 1600 cycles. frame_start must pulse once per 420000 cycles.
- RAM model returning data = addr[11:0]. Pixel (3,0) must give g=0x0, r=0x0, b=0x3. The last fb_addr of a frame must be 307199. fb_re must be high for 307200 cycles.
- Data 0xFFF driven on fb_data throughout blanking: r/g/b must be 0 whenever vga_de = 0.
- SCALE_SHIFT=1, FB_W=320: pixel (5,3) reads address 322. Each address is issued on 2 consecutive cycles. Lines 2k and 2k+1 issue identical address sequences. The last address is 76799.
- rst_n low for 5 cycles at pixel (300,200):
  - all outputs hold their reset values during reset;
  - fb_addr = 0 on the first cycle after release;
  - frame_start follows 3 cycles after release with no partial frame.
- Replace the counter wrap check with a forced h_cnt=799, v_cnt=524 state. The next pixel must be (0,0) with fb_addr = 0, and line_base must be cleared.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA / frame-buffer definitions.
// Holds the default 640x480@60 timing constants, the derived line and frame
// totals, and the 12-bit stored pixel layout (G 11:8, R 7:4, B 3:0). The
// capture block uses the same layout. No ports.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned H_FP_DEF        = 16;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BP_DEF        = 48;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned V_FP_DEF        = 10;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BP_DEF        = 33;
  localparam int unsigned H_TOTAL_DEF     = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF     = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned FB_W_DEF        = 640;
  localparam int unsigned SCALE_SHIFT_DEF = 0;
  localparam int unsigned ADDR_W_DEF      = 19;

  localparam int unsigned PIX_G_HI = 11;
  localparam int unsigned PIX_G_LO = 8;
  localparam int unsigned PIX_R_HI = 7;
  localparam int unsigned PIX_R_LO = 4;
  localparam int unsigned PIX_B_HI = 3;
  localparam int unsigned PIX_B_LO = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t unpack_pixel(input logic [11:0] pix);
    rgb_t c;
    c.r = pix[PIX_R_HI:PIX_R_LO];
    c.g = pix[PIX_G_HI:PIX_G_LO];
    c.b = pix[PIX_B_HI:PIX_B_LO];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters.
// Ports: pclk, rst_n (sync, active-low); h_cnt / v_cnt raster position;
// active (visible pixel), line_active (visible line), hsync_n / vsync_n raw
// active-low syncs, line_end (last pixel of a line), frame_end (last pixel of
// a frame), frame_first (pixel 0,0). All flags are decoded from the counters.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          pclk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          line_active,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          line_end,
  output logic          frame_end,
  output logic          frame_first
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    line_active = (v_cnt < V_ACT);
    active      = (h_cnt < H_ACT) && line_active;
    hsync_n     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vsync_n     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    line_end    = (h_cnt == H_LAST);
    frame_end   = line_end && (v_cnt == V_LAST);
    frame_first = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader with VGA output.
// Ports: pclk, rst_n (sync, active-low); fb_addr / fb_re registered read
// request to a synchronous RAM; fb_data 12-bit pixel returned one cycle later;
// vga_r/g/b colour, vga_hsync_n / vga_vsync_n syncs, vga_de data enable and
// frame_start pulse, all registered and aligned on the same cycle.
// Pipeline: counters -> fb_addr/fb_re -> RAM data -> pins.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned FB_W        = FB_W_DEF,
  parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic              pclk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_re,
  input  logic [11:0]       fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync_n,
  output logic              vga_vsync_n,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Low SCALE_SHIFT bits of v_cnt; all ones marks the last replicated line.
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active;
  logic          line_active;
  logic          hsync_raw_n;
  logic          vsync_raw_n;
  logic          line_end;
  logic          frame_end;
  logic          frame_first;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .line_active (line_active),
    .hsync_n     (hsync_raw_n),
    .vsync_n     (vsync_raw_n),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  // Address generation: line_base accumulates FB_W per stored line, so no
  // multiplier is needed. It advances once per group of 2^SCALE_SHIFT lines.
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] pix_addr;

  always_comb pix_addr = line_base + ADDR_W'(h_cnt >> SCALE_SHIFT);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      line_base <= '0;
    end else if (frame_end) begin
      line_base <= '0;
    end else if (line_end && line_active && ((v_cnt & V_MASK) == V_MASK)) begin
      line_base <= line_base + ADDR_W'(FB_W);
    end
  end

  // Stage 1: read request plus the control bits that travel with it.
  logic s1_hs_n, s1_vs_n, s1_fs;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      fb_addr <= '0;
      fb_re   <= 1'b0;
      s1_hs_n <= 1'b1;
      s1_vs_n <= 1'b1;
      s1_fs   <= 1'b0;
    end else begin
      fb_re   <= active;
      if (active) fb_addr <= pix_addr;
      s1_hs_n <= hsync_raw_n;
      s1_vs_n <= vsync_raw_n;
      s1_fs   <= frame_first;
    end
  end

  // Stage 2: matches the RAM read latency.
  logic s2_de, s2_hs_n, s2_vs_n, s2_fs;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      s2_de   <= 1'b0;
      s2_hs_n <= 1'b1;
      s2_vs_n <= 1'b1;
      s2_fs   <= 1'b0;
    end else begin
      s2_de   <= fb_re;
      s2_hs_n <= s1_hs_n;
      s2_vs_n <= s1_vs_n;
      s2_fs   <= s1_fs;
    end
  end

  // Stage 3: output pins; colour is blanked outside the active area.
  rgb_t pix;
  always_comb pix = unpack_pixel(fb_data);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= s2_de ? pix.r : '0;
      vga_g       <= s2_de ? pix.g : '0;
      vga_b       <= s2_de ? pix.b : '0;
      vga_de      <= s2_de;
      vga_hsync_n <= s2_hs_n;
      vga_vsync_n <= s2_vs_n;
      frame_start <= s2_fs;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader using reduced raster timing so whole frames fit in
// a short run. Two instances: 1:1 scaling and 2x2 scaling. Each is fed by a
// synchronous RAM returning addr[11:0] on reads and 0xFFF otherwise.
module tb_vga_fb_reader;

  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;   // 25
  localparam int unsigned VT = VA + VF + VS + VB;   // 13
  localparam int unsigned FT = HT * VT;             // 325
  localparam int unsigned W0 = 16, S0 = 0;
  localparam int unsigned W1 = 8,  S1 = 1;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;

  logic [18:0] addr0, addr1;
  logic        re0, re1;
  logic [11:0] data0 = 12'hFFF, data1 = 12'hFFF;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;

  always #5 pclk = ~pclk;

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_W(W0), .SCALE_SHIFT(S0), .ADDR_W(19)
  ) dut0 (
    .pclk(pclk), .rst_n(rst_n), .fb_addr(addr0), .fb_re(re0), .fb_data(data0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync_n(hs0), .vga_vsync_n(vs0),
    .vga_de(de0), .frame_start(fs0)
  );

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_W(W1), .SCALE_SHIFT(S1), .ADDR_W(19)
  ) dut1 (
    .pclk(pclk), .rst_n(rst_n), .fb_addr(addr1), .fb_re(re1), .fb_data(data1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync_n(hs1), .vga_vsync_n(vs1),
    .vga_de(de1), .frame_start(fs1)
  );

  always @(posedge pclk) begin
    data0 <= re0 ? addr0[11:0] : 12'hFFF;
    data1 <= re1 ? addr1[11:0] : 12'hFFF;
  end

  // Edges since release: after edge E_j, cyc == j+1.
  int unsigned cyc = 0;
  logic        in_rst = 1'b1;
  always @(posedge pclk) begin
    if (!rst_n) begin
      cyc    <= 0;
      in_rst <= 1'b1;
    end else begin
      cyc    <= cyc + 1;
      in_rst <= 1'b0;
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference raster model: position p counts pixels from (0,0) of a frame.
  function automatic int unsigned hpos(input int unsigned p);
    return (p % FT) % HT;
  endfunction
  function automatic int unsigned vpos(input int unsigned p);
    return (p % FT) / HT;
  endfunction
  function automatic bit is_act(input int unsigned p);
    return (hpos(p) < HA) && (vpos(p) < VA);
  endfunction
  function automatic int unsigned addr_of(input int unsigned p, input int unsigned s,
                                          input int unsigned w);
    return (vpos(p) >> s) * w + (hpos(p) >> s);
  endfunction

  task automatic check_reset(input string nm, input logic [18:0] a, input logic re,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic hs, input logic vs, input logic de, input logic fs);
    chk({nm, ".rst_addr"}, 32'(a), 0);
    chk({nm, ".rst_re"}, 32'(re), 0);
    chk({nm, ".rst_rgb"}, 32'({r, g, b}), 0);
    chk({nm, ".rst_hs"}, 32'(hs), 1);
    chk({nm, ".rst_vs"}, 32'(vs), 1);
    chk({nm, ".rst_de"}, 32'(de), 0);
    chk({nm, ".rst_fs"}, 32'(fs), 0);
  endtask

  task automatic check_dut(input string nm, input int unsigned j, input int unsigned s,
                           input int unsigned w, input logic [18:0] a, input logic re,
                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                           input logic hs, input logic vs, input logic de, input logic fs,
                           input int unsigned last_addr, output int unsigned new_addr);
    int unsigned ea, p, h, v, pix;
    bit e_de;
    ea = is_act(j) ? addr_of(j, s, w) : last_addr;
    new_addr = ea;
    chk({nm, ".fb_re"}, 32'(re), 32'(is_act(j)));
    chk({nm, ".fb_addr"}, 32'(a), ea);
    if (j < 2) begin
      chk({nm, ".fill_de"}, 32'(de), 0);
      chk({nm, ".fill_hs"}, 32'(hs), 1);
      chk({nm, ".fill_vs"}, 32'(vs), 1);
      chk({nm, ".fill_fs"}, 32'(fs), 0);
      chk({nm, ".fill_rgb"}, 32'({r, g, b}), 0);
    end else begin
      p    = j - 2;
      h    = hpos(p);
      v    = vpos(p);
      e_de = is_act(p);
      pix  = e_de ? (addr_of(p, s, w) & 32'hFFF) : 0;
      chk({nm, ".de"}, 32'(de), 32'(e_de));
      chk({nm, ".hsync_n"}, 32'(hs), 32'(!(h >= HA + HF && h < HA + HF + HS)));
      chk({nm, ".vsync_n"}, 32'(vs), 32'(!(v >= VA + VF && v < VA + VF + VS)));
      chk({nm, ".frame_start"}, 32'(fs), 32'(h == 0 && v == 0));
      chk({nm, ".r"}, 32'(r), (pix >> 4) & 15);
      chk({nm, ".g"}, 32'(g), (pix >> 8) & 15);
      chk({nm, ".b"}, 32'(b), pix & 15);
    end
  endtask

  // Compare process plus interval measurements on the 1:1 instance.
  int unsigned last0 = 0, last1 = 0;
  logic        p_hs = 1'b1, p_vs = 1'b1, p_de = 1'b0;
  int unsigned de_rise_j = 0, fs_prev_j = 0, hs_low = 0, vs_low = 0, re_cnt = 0;
  bit          de_rise_ok = 0, fs_prev_ok = 0, hs_fell = 0, vs_fell = 0;

  always @(negedge pclk) begin
    int unsigned j;
    if (in_rst) begin
      check_reset("d0", addr0, re0, r0, g0, b0, hs0, vs0, de0, fs0);
      check_reset("d1", addr1, re1, r1, g1, b1, hs1, vs1, de1, fs1);
      last0 = 0; last1 = 0;
      p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0;
      de_rise_ok = 0; fs_prev_ok = 0; hs_fell = 0; vs_fell = 0;
      hs_low = 0; vs_low = 0; re_cnt = 0;
    end else begin
      j = cyc - 1;
      check_dut("d0", j, S0, W0, addr0, re0, r0, g0, b0, hs0, vs0, de0, fs0, last0, last0);
      check_dut("d1", j, S1, W1, addr1, re1, r1, g1, b1, hs1, vs1, de1, fs1, last1, last1);

      // Hand-computed literal expectations.
      if (j == 0) begin
        chk("lit.release_addr", 32'(addr0), 0);
        chk("lit.release_re", 32'(re0), 1);
      end
      if (j == 2) begin
        chk("lit.first_fs", 32'(fs0), 1);
        chk("lit.first_de", 32'(de0), 1);
      end
      if (j == 5) chk("lit.pix30_rgb", 32'({g0, r0, b0}), 32'h003);
      if (j == 79 || j == 80) chk("lit.scaled_pix_addr", 32'(addr1), 10);
      if (j == 81) chk("lit.scaled_next_addr", 32'(addr1), 11);
      if (j % FT == HT * (VA - 1) + HA) begin
        chk("lit.last_addr_d0", 32'(addr0), 127);
        chk("lit.last_addr_d1", 32'(addr1), 31);
      end
      if (j > 0 && j % FT == 0) begin
        chk("lit.wrap_addr_d0", 32'(addr0), 0);
        chk("lit.wrap_addr_d1", 32'(addr1), 0);
        chk("lit.wrap_re", 32'(re0), 1);
      end

      // Interval measurements.
      if (de0 && !p_de) begin de_rise_j = j; de_rise_ok = 1; end
      if (!hs0 && p_hs) begin
        if (de_rise_ok) chk("hs_fall_after_de", j - de_rise_j, HA + HF);
        de_rise_ok = 0; hs_fell = 1; hs_low = 0;
      end
      if (!hs0) hs_low++;
      if (hs0 && !p_hs && hs_fell) chk("hs_low_len", hs_low, HS);
      if (!vs0 && p_vs) begin vs_fell = 1; vs_low = 0; end
      if (!vs0) vs_low++;
      if (vs0 && !p_vs && vs_fell) chk("vs_low_len", vs_low, VS * HT);
      if (fs0) begin
        if (fs_prev_ok) begin
          chk("fs_period", j - fs_prev_j, FT);
          chk("re_per_frame", re_cnt, HA * VA);
        end
        fs_prev_j = j; fs_prev_ok = 1; re_cnt = 0;
      end
      if (re0) re_cnt++;
      p_hs = hs0; p_vs = vs0; p_de = de0;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) @(negedge pclk);
    rst_n = 1'b1;
    // Two full frames, then into frame 3 to mid-frame position (5,3).
    repeat (2 * FT + 3 * HT + 5) @(negedge pclk);
    rst_n = 1'b0;
    repeat (5) @(negedge pclk);
    rst_n = 1'b1;
    repeat (FT + 40) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
